// File: rtl/spi_pkg.sv
// Shared SPI widths and types used by the controller and its requester-side arbiter.
// Defaults here keep every SPI block agreeing on word and peripheral-address widths.
package spi_pkg;

    localparam int DEF_SPI_DATA_WIDTH = 8;
    localparam int DEF_P_ADDR_WIDTH   = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } spi_arb_state_t;

    // Cyclic successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and controller-side signals of the SPI transaction arbiter.
// master = arbiter side, slave = requesters plus spi_controller.
interface spi_txn_arbiter_if
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = DEF_SPI_DATA_WIDTH,
    parameter int AW      = DEF_P_ADDR_WIDTH
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic                  start_txn;
    logic [DW-1:0]         tx_data;
    logic [AW-1:0]         p_addr;
    logic                  end_txn;
    logic                  busy;
    logic [IDW-1:0]        grant_id;

    modport master (
        input  req, req_data, req_addr, end_txn,
        output req_ack, req_done, req_err, start_txn, tx_data, p_addr, busy, grant_id
    );

    modport slave (
        output req, req_data, req_addr, end_txn,
        input  req_ack, req_done, req_err, start_txn, tx_data, p_addr, busy, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, searching cyclically.
// Zero latency; no state, so the caller owns pointer advance and any backpressure.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = IDW'((int'(ptr) + off) % N);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_controller among NUM_REQ requesters: round-robin grant, one start_txn, watchdog on end_txn.
// req->ack 1 enabled edge, ack->start 1, end_txn->done 1; requests simply wait on their req level while busy.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SPI_DATA_WIDTH = DEF_SPI_DATA_WIDTH,
    parameter int P_ADDR_WIDTH   = DEF_P_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              async_rst_n,
    input  logic              sys_clk_en,
    spi_txn_arbiter_if.master bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 1);

    spi_arb_state_t            state_q, state_d;
    logic [IDW-1:0]            rr_ptr_q, grant_id_q, win_idx;
    logic [NUM_REQ-1:0]        win_gnt, grant_oh, ack_q, done_q, err_q;
    logic                      win_vld;
    logic [SPI_DATA_WIDTH-1:0] tx_data_q;
    logic [P_ADDR_WIDTH-1:0]   p_addr_q;
    logic                      start_q;
    logic [CW-1:0]             cnt_q;
    logic                      do_grant, do_issue, do_done, do_err;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .gnt     (win_gnt),
        .gnt_idx (win_idx),
        .gnt_vld (win_vld)
    );

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_issue = 1'b0;
        do_done  = 1'b0;
        do_err   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    state_d  = ARB_ISSUE;
                    do_grant = 1'b1;
                end
            end
            ARB_ISSUE: begin
                state_d  = ARB_WAIT;
                do_issue = 1'b1;
            end
            ARB_WAIT: begin
                // Completion beats the watchdog when both land on the terminal edge.
                if (bus.end_txn) begin
                    state_d = ARB_DONE;
                    do_done = 1'b1;
                end else if (cnt_q == CNT_TERM) begin
                    state_d = ARB_IDLE;
                    do_err  = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ARB_IDLE;
        end else if (sys_clk_en) begin
            state_q <= state_d;
        end
    end

    assign grant_oh = NUM_REQ'(1) << grant_id_q;

    // Pulses clear on every edge but are only set on enabled ones, so they stay one sys_clk wide.
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            p_addr_q   <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            if (sys_clk_en) begin
                start_q <= do_issue;
                if (do_grant) begin
                    tx_data_q  <= bus.req_data[win_idx*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                    p_addr_q   <= bus.req_addr[win_idx*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                    grant_id_q <= win_idx;
                    ack_q      <= win_gnt;
                    rr_ptr_q   <= IDW'(rr_next(int'(win_idx), NUM_REQ));
                end
                if (do_issue) begin
                    cnt_q <= '0;
                end else if (state_q == ARB_WAIT && state_d == ARB_WAIT) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (do_done) done_q <= grant_oh;
                if (do_err)  err_q  <= grant_oh;
            end
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.req_done  = done_q;
    assign bus.req_err   = err_q;
    assign bus.start_txn = start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.p_addr    = p_addr_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomised bench for spi_txn_arbiter: a transaction-level model predicts grants and outcomes into a
// scoreboard queue; a negedge monitor pops and compares every ack/start/done/err it sees.
module tb_spi_txn_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int TO = 16;
    localparam int K_ACK = 0, K_START = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int kind;
        int id;
        int data;
        int addr;
    } exp_t;

    exp_t sb[$];
    int   ack_log[$];

    logic sys_clk = 1'b0;
    logic async_rst_n;
    logic sys_clk_en;

    int checks = 0, passes = 0;
    int en_edges = 0, end_stamp = 0, last_ack = 0, last_start = 0, ev_count = 0;
    bit en_toggle = 1'b0;
    bit pend[NR];
    int rdata[NR];
    int raddr[NR];
    int ptr = 0;

    spi_txn_arbiter_if #(.NUM_REQ(NR), .DW(DW), .AW(AW)) bus ();

    spi_txn_arbiter #(
        .NUM_REQ(NR), .SPI_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk     (sys_clk),
        .async_rst_n (async_rst_n),
        .sys_clk_en  (sys_clk_en),
        .bus         (bus)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        if (sys_clk_en && async_rst_n) en_edges++;
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        sys_clk_en = en_toggle ? ~sys_clk_en : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic observe(input int kind, input logic [NR-1:0] vec);
        exp_t e;
        logic [NR-1:0] oh;
        ev_count++;
        if (sb.size() == 0) begin
            check(1'b0, "unexpected_event", kind, -1);
            return;
        end
        e  = sb.pop_front();
        oh = NR'(1) << e.id;
        check(kind == e.kind, "event_kind", kind, e.kind);
        case (kind)
            K_ACK: begin
                check(vec == oh, "ack_onehot", int'(vec), int'(oh));
                check(int'(bus.grant_id) == e.id, "grant_id", int'(bus.grant_id), e.id);
                ack_log.push_back(int'(bus.grant_id));
                last_ack = en_edges;
            end
            K_START: begin
                check(int'(bus.tx_data) == e.data, "start_tx_data", int'(bus.tx_data), e.data);
                check(int'(bus.p_addr) == e.addr, "start_p_addr", int'(bus.p_addr), e.addr);
                check(en_edges - last_ack == 1, "start_latency", en_edges - last_ack, 1);
                last_start = en_edges;
            end
            K_DONE: begin
                check(vec == oh, "done_onehot", int'(vec), int'(oh));
                check(en_edges == end_stamp, "done_latency", en_edges, end_stamp);
            end
            default: begin
                check(vec == oh, "err_onehot", int'(vec), int'(oh));
                check(en_edges - last_start == TO, "err_latency", en_edges - last_start, TO);
            end
        endcase
    endtask

    initial begin
        bit sp;
        sp = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!async_rst_n) begin
                sp = 1'b0;
            end else begin
                if (|bus.req_ack) observe(K_ACK, bus.req_ack);
                if (bus.start_txn && !sp) observe(K_START, '0);
                sp = bus.start_txn;
                if (|bus.req_done) observe(K_DONE, bus.req_done);
                if (|bus.req_err) observe(K_ERR, bus.req_err);
            end
        end
    end

    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            bus.req[i] = pend[i];
            bus.req_data[i*DW +: DW] = DW'(rdata[i]);
            bus.req_addr[i*AW +: AW] = AW'(raddr[i]);
        end
    endtask

    task automatic raise(input int i, input int d, input int a);
        pend[i]  = 1'b1;
        rdata[i] = d;
        raddr[i] = a;
        drive_req();
    endtask

    task automatic drop_all();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive_req();
    endtask

    task automatic full_reset();
        @(negedge sys_clk);
        async_rst_n = 1'b0;
        en_toggle   = 1'b0;
        bus.end_txn = 1'b0;
        drop_all();
        @(negedge sys_clk);
        async_rst_n = 1'b1;
        ptr = 0;
    endtask

    // Runs one transaction: predict the winner from the pending set, then play the controller side.
    // end_delay = enabled WAIT edge on which end_txn is sampled (0 = never).
    task automatic do_round(input int end_delay, input bit tog, input bit rst_mid, output int g);
        int k, guard, idx, cd, ca;
        en_toggle = tog;
        g = -1;
        for (int j = 0; j < NR; j++) begin
            idx = (ptr + j) % NR;
            if (g < 0 && pend[idx]) g = idx;
        end
        if (g < 0) return;
        cd = rdata[g];
        ca = raddr[g];
        sb.push_back('{K_ACK, g, cd, ca});
        sb.push_back('{K_START, g, cd, ca});
        if (!rst_mid)
            sb.push_back('{(end_delay == 0 || end_delay > TO) ? K_DONE + 1 : K_DONE, g, cd, ca});
        ptr = (g + 1) % NR;

        guard = 0;
        do begin
            @(negedge sys_clk);
            guard++;
        end while (bus.req_ack == '0 && guard < 200);
        check(guard < 200, "ack_wait", guard, 200);
        pend[g] = 1'b0;
        drive_req();

        guard = 0;
        while (!bus.start_txn && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        check(guard < 200, "start_wait", guard, 200);

        if (rst_mid) begin
            #2;
            async_rst_n = 1'b0;
            #1;
            check(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
            check(bus.start_txn == 1'b0, "rst_start_txn", int'(bus.start_txn), 0);
            check({bus.req_ack, bus.req_done, bus.req_err} == '0, "rst_pulses",
                  int'({bus.req_ack, bus.req_done, bus.req_err}), 0);
            drop_all();
            en_toggle = 1'b0;
            @(negedge sys_clk);
            @(negedge sys_clk);
            async_rst_n = 1'b1;
            ptr = 0;
            return;
        end

        k = 0;
        guard = 0;
        forever begin
            bus.end_txn = 1'b0;
            if (sys_clk_en) begin
                k++;
                if (k == end_delay) begin
                    bus.end_txn = 1'b1;
                    end_stamp   = en_edges + 1;
                end
            end
            @(negedge sys_clk);
            if (!bus.busy) break;
            check(int'(bus.tx_data) == cd && int'(bus.p_addr) == ca, "hold_tx_data",
                  int'(bus.tx_data) * 4 + int'(bus.p_addr), cd * 4 + ca);
            guard++;
            if (guard > 300) begin
                check(1'b0, "busy_wait", guard, 300);
                break;
            end
        end
        bus.end_txn = 1'b0;
    endtask

    initial begin
        int g, c0, ed;
        int fair_exp[5];
        fair_exp = '{0, 1, 2, 3, 0};
        sys_clk_en   = 1'b1;
        async_rst_n  = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_addr = '0;
        bus.end_txn  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; rdata[i] = 0; raddr[i] = 0;
        end
        repeat (3) @(negedge sys_clk);
        check(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
        check(bus.start_txn == 1'b0, "reset_start_txn", int'(bus.start_txn), 0);
        check({bus.req_ack, bus.req_done, bus.req_err} == '0, "reset_pulses",
              int'({bus.req_ack, bus.req_done, bus.req_err}), 0);
        check(bus.grant_id == '0, "reset_grant_id", int'(bus.grant_id), 0);
        check(bus.tx_data == '0 && bus.p_addr == '0, "reset_tx", int'(bus.tx_data), 0);
        async_rst_n = 1'b1;
        @(negedge sys_clk);

        raise(0, 8'hA5, 2);
        do_round(3, 1'b0, 1'b0, g);
        check(bus.busy == 1'b0, "single_busy_after", int'(bus.busy), 0);

        full_reset();
        ack_log.delete();
        for (int i = 0; i < NR; i++) raise(i, $urandom_range(0, 255), $urandom_range(0, 3));
        for (int r = 0; r < 5; r++) begin
            do_round(3, 1'b0, 1'b0, g);
            if (g >= 0) raise(g, $urandom_range(0, 255), $urandom_range(0, 3));
        end
        drop_all();
        check(ack_log.size() == 5, "fair_count", ack_log.size(), 5);
        for (int r = 0; r < 5; r++)
            check(r < ack_log.size() && ack_log[r] == fair_exp[r], "fair_order",
                  (r < ack_log.size()) ? ack_log[r] : -1, fair_exp[r]);

        raise(1, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(0, 1'b0, 1'b0, g);
        raise(2, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(0, 1'b1, 1'b0, g);
        raise(3, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(7, 1'b1, 1'b0, g);
        raise(0, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(TO, 1'b0, 1'b0, g);
        raise(1, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(TO + 1, 1'b0, 1'b0, g);

        c0 = ev_count;
        bus.end_txn = 1'b1;
        repeat (3) @(negedge sys_clk);
        bus.end_txn = 1'b0;
        repeat (2) @(negedge sys_clk);
        check(ev_count == c0, "idle_end_ignored", ev_count - c0, 0);
        check(bus.busy == 1'b0, "idle_end_busy", int'(bus.busy), 0);

        repeat (40) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    raise(i, $urandom_range(0, 255), $urandom_range(0, 3));
            ed = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TO + 2);
            do_round(ed, 1'($urandom_range(0, 1)), 1'b0, g);
        end
        drop_all();

        raise(1, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(0, 1'b0, 1'b1, g);
        raise(2, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(2, 1'b0, 1'b0, g);
        check(g == 2, "post_reset_grant", g, 2);
        raise(0, $urandom_range(0, 255), $urandom_range(0, 3));
        raise(1, $urandom_range(0, 255), $urandom_range(0, 3));
        do_round(4, 1'b0, 1'b0, g);
        do_round(5, 1'b0, 1'b0, g);

        repeat (5) @(negedge sys_clk);
        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Shares one spi_controller between NUM_REQ on-chip requesters, for example the CPU, the boot loader and a sensor poller. It arbitrates pending requests round-robin and latches the winner's data and peripheral address. It then issues a single start_txn to the controller and waits for end_txn, with a watchdog timeout. Completion or error is reported back to the granted requester. The block sits between the requesters and spi_controller and runs in the sys_clk / sys_clk_en domain.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
SPI_DATA_WIDTH, 8, transaction word width; matches spi_controller
P_ADDR_WIDTH, 2, peripheral-select address width; matches spi_controller
TIMEOUT_CYCLES, 4096, enabled cycles allowed in WAIT before abort (≥2)

Ports:
sys_clk  in  1  system clock
async_rst_n  in  1  asynchronous active-low reset
sys_clk_en  in  1  clock enable; all state advances only when high
req  in  NUM_REQ  per-requester request level, held until req_ack
req_data  in  NUM_REQ*SPI_DATA_WIDTH  flattened tx words; slice i belongs to requester i
req_addr  in  NUM_REQ*P_ADDR_WIDTH  flattened peripheral addresses
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted, data latched
req_done  out  NUM_REQ  one-hot, 1-cycle pulse: transaction completed
req_err  out  NUM_REQ  one-hot, 1-cycle pulse: transaction timed out
start_txn  out  1  to spi_controller; data valid / start
tx_data  out  SPI_DATA_WIDTH  to spi_controller; registered
p_addr  out  P_ADDR_WIDTH  to spi_controller; registered
end_txn  in  1  from spi_controller; transaction finished
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  index of current or last grant

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. rr_ptr=0, meaning requester 0 has highest priority. timeout counter=0.
- When sys_clk_en=0, nothing changes. State, counters and outputs hold. Pulse outputs still last exactly one sys_clk cycle, because they are asserted only on enabled edges and cleared on the next edge.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On an enabled edge with |req: pick g = the first asserted req at or after rr_ptr, searching cyclically.
  - Latch req_data[g] into tx_data and req_addr[g] into p_addr. Set grant_id=g and pulse req_ack[g].
  - Set rr_ptr=(g+1) mod NUM_REQ and go to ISSUE.
- ISSUE:
  - start_txn=1 for exactly one enabled cycle, then go to WAIT.
  - Clear the timeout counter on entry to WAIT.
- WAIT:
  - start_txn=0. tx_data and p_addr stay stable.
  - end_txn=1 on an enabled edge: go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no end_txn, pulse req_err[grant_id] and go to IDLE.
  - end_txn on the same edge the counter reaches its terminal value: completion wins, so go to DONE with no error.
- DONE: pulse req_done[grant_id], then go to IDLE. A new grant is possible on the following enabled edge.
- Latency:
  - req high in IDLE to req_ack: 1 enabled edge.
  - req_ack to start_txn: 1 enabled edge.
  - end_txn to req_done: 1 enabled edge.
- end_txn seen in IDLE, ISSUE or DONE is ignored.
- A requester deasserting req before it is acked is dropped silently. Requests arriving during busy wait; they are not queued beyond their req level.
- A requester may re-request immediately after req_done. Round-robin still gives every other pending requester a turn first.
- Reset mid-WAIT: no done or err pulse is produced, and start_txn is forced to 0.
- Width rule: the timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps, since it is cleared on WAIT entry.

Decomposition:
- Shared package spi_pkg, extending spi_params: add typedef enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} spi_arb_state_t.
- Move SPI_DATA_WIDTH and P_ADDR_WIDTH defaults into the same package.
- One sub-module, rr_arbiter (req vector, rr_ptr → one-hot grant plus index). It is purely combinational and reusable elsewhere.

Test Plan:
- Single request: req=0001, req_data[0]=8'hA5, req_addr[0]=2 → req_ack=0001 one edge later; start_txn one cycle with tx_data=A5, p_addr=2; end_txn → req_done=0001 next edge; busy low after.
- Fairness: req=1111 held, auto end_txn 3 cycles after start → grant order 0,1,2,3,0 with one ack per transaction.
- Timeout: TIMEOUT_CYCLES=16, no end_txn → req_err[g] pulses exactly 16 enabled cycles after WAIT entry; FSM back in IDLE, no req_done.
- Clock enable: sys_clk_en toggled 1/0 every cycle during WAIT → timeout takes 2× sys_clk cycles; outputs hold on disabled cycles.
- Reset mid-WAIT: assert async_rst_n=0 between clock edges → busy, start_txn and all pulses 0 immediately; after release, req=0100 is granted before requester 0.
- Boundary: end_txn on the terminal timeout edge → req_done asserted, req_err not; spurious end_txn in IDLE → no pulse.
